// File: rtl/led_div_pkg.sv
// Shared types, default parameters and half-period helper for the LED divider.
package led_div_pkg;

   localparam int NUM_CH_DEF    = 3;
   localparam int CNT_W_DEF     = 26;
   localparam int DIV_RESET_DEF = 50000000;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_BND,
      S_COMMIT
   } cfg_state_e;

   // Divisors below 2 behave as 2; odd divisors round down.
   function automatic logic [31:0] half_period(input logic [31:0] div);
      return (div < 32'd2) ? 32'd1 : (div >> 1);
   endfunction

endpackage

// File: rtl/div_channel.sv
// One LED divider channel: half-period counter, toggle output, load port.
module div_channel
   import led_div_pkg::*;
#(
   parameter int CNT_W     = CNT_W_DEF,
   parameter int DIV_RESET = DIV_RESET_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] ld_div,
   input  logic             ld_en,
   output logic             en,
   output logic             bnd,
   output logic             led
);

   logic [CNT_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             en_q, en_d;
   logic             led_q, led_d;
   logic [CNT_W-1:0] half;

   assign half = CNT_W'(half_period(32'(div_q)));
   assign bnd  = en_q && (cnt_q == half - CNT_W'(1));
   assign en   = en_q;
   assign led  = led_q;

   always_comb begin
      div_d = div_q;
      en_d  = en_q;
      cnt_d = cnt_q;
      led_d = led_q;
      if (load) begin
         // A commit overrides any boundary in the same cycle.
         div_d = ld_div;
         en_d  = ld_en;
         cnt_d = '0;
         led_d = ld_en ? led_q : 1'b0;
      end else if (!en_q) begin
         cnt_d = '0;
         led_d = 1'b0;
      end else if (bnd) begin
         cnt_d = '0;
         led_d = ~led_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= CNT_W'(DIV_RESET);
         en_q  <= 1'b1;
         cnt_q <= '0;
         led_q <= 1'b0;
      end else begin
         div_q <= div_d;
         en_q  <= en_d;
         cnt_q <= cnt_d;
         led_q <= led_d;
      end
   end

endmodule

// File: rtl/led_divider_ctrl.sv
// Multi-channel LED divider with a glitch-free, boundary-aligned config FSM.
module led_divider_ctrl
   import led_div_pkg::*;
#(
   parameter int NUM_CH    = NUM_CH_DEF,
   parameter int CNT_W     = CNT_W_DEF,
   parameter int DIV_RESET = DIV_RESET_DEF
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [1:0]        cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   input  logic              cfg_en,
   output logic [NUM_CH-1:0] LED,
   output logic              busy
);

   cfg_state_e        state_q, state_d;
   logic [1:0]        req_ch_q, req_ch_d;
   logic [CNT_W-1:0]  req_div_q, req_div_d;
   logic              req_en_q, req_en_d;
   logic [NUM_CH-1:0] ch_en, ch_bnd, ch_load;
   logic [3:0]        en_pad, bnd_pad;
   logic              ch_ok;

   assign en_pad  = 4'(ch_en);
   assign bnd_pad = 4'(ch_bnd);
   assign ch_ok   = 32'(cfg_ch) < 32'(NUM_CH);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign ch_load[i] = (state_q == S_COMMIT) && (req_ch_q == 2'(i));

      div_channel #(
         .CNT_W    (CNT_W),
         .DIV_RESET(DIV_RESET)
      ) u_ch (
         .clk   (CLK),
         .rst_n (RST_N),
         .load  (ch_load[i]),
         .ld_div(req_div_q),
         .ld_en (req_en_q),
         .en    (ch_en[i]),
         .bnd   (ch_bnd[i]),
         .led   (LED[i])
      );
   end

   always_comb begin
      state_d   = state_q;
      req_ch_d  = req_ch_q;
      req_div_d = req_div_q;
      req_en_d  = req_en_q;
      cfg_ready = (state_q == S_IDLE);
      busy      = (state_q != S_IDLE);
      unique case (state_q)
         S_IDLE: begin
            if (cfg_valid) begin
               req_ch_d  = cfg_ch;
               req_div_d = cfg_div;
               req_en_d  = cfg_en;
               // Only a running channel needs to wait for its boundary.
               if (!ch_ok || !en_pad[cfg_ch] || !cfg_en) begin
                  state_d = S_COMMIT;
               end else begin
                  state_d = S_WAIT_BND;
               end
            end
         end
         S_WAIT_BND: begin
            if (bnd_pad[req_ch_q]) begin
               state_d = S_COMMIT;
            end
         end
         S_COMMIT: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= S_IDLE;
         req_ch_q  <= '0;
         req_div_q <= '0;
         req_en_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_ch_q  <= req_ch_d;
         req_div_q <= req_div_d;
         req_en_q  <= req_en_d;
      end
   end

endmodule

// File: tb/tb_led_divider_ctrl.sv
// Bench for led_divider_ctrl: countdown-based reference model plus
// directed vectors with hand-computed waveform expectations.
module tb_led_divider_ctrl;

   localparam int NUM_CH = 3;
   localparam int CNT_W  = 8;
   localparam int DIVR   = 8;

   logic             CLK = 1'b0;
   logic             RST_N = 1'b0;
   logic             cfg_valid = 1'b0;
   logic             cfg_ready;
   logic [1:0]       cfg_ch = '0;
   logic [CNT_W-1:0] cfg_div = '0;
   logic             cfg_en = 1'b0;
   logic [2:0]       LED;
   logic             busy;

   int n_cmp = 0;
   int n_err = 0;

   led_divider_ctrl #(
      .NUM_CH   (NUM_CH),
      .CNT_W    (CNT_W),
      .DIV_RESET(DIVR)
   ) dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_ch   (cfg_ch),
      .cfg_div  (cfg_div),
      .cfg_en   (cfg_en),
      .LED      (LED),
      .busy     (busy)
   );

   initial forever #5 CLK = ~CLK;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: each channel counts edges left until its next toggle.
   int m_half[NUM_CH];
   int m_left[NUM_CH];
   bit m_en[NUM_CH];
   bit m_led[NUM_CH];
   bit m_tog[NUM_CH];
   int m_ph;
   int r_ch;
   int r_half;
   bit r_en;
   int m_ld;

   function automatic int clamp_half(input int d);
      return (d < 2) ? 1 : d / 2;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         m_half[i] = clamp_half(DIVR);
         m_left[i] = m_half[i];
         m_en[i]   = 1'b1;
         m_led[i]  = 1'b0;
      end
      m_ph = 0;
   endtask

   function automatic logic [2:0] exp_led();
      logic [2:0] v;
      for (int i = 0; i < NUM_CH; i++) v[i] = m_led[i];
      return v;
   endfunction

   initial begin
      model_reset();
      forever begin
         @(posedge CLK or negedge RST_N);
         if (!RST_N) begin
            model_reset();
         end else begin
            m_ld = -1;
            for (int i = 0; i < NUM_CH; i++)
               m_tog[i] = m_en[i] && (m_left[i] == 1);
            case (m_ph)
               0: if (cfg_valid) begin
                  r_ch   = int'(cfg_ch);
                  r_half = clamp_half(int'(cfg_div));
                  r_en   = cfg_en;
                  if (r_ch >= NUM_CH || !m_en[r_ch] || !r_en) m_ph = 2;
                  else m_ph = 1;
               end
               1: if (m_tog[r_ch]) m_ph = 2;
               default: begin
                  m_ld = r_ch;
                  m_ph = 0;
               end
            endcase
            for (int i = 0; i < NUM_CH; i++) begin
               if (i == m_ld) begin
                  m_en[i]   = r_en;
                  m_half[i] = r_half;
                  m_left[i] = r_half;
                  if (!r_en) m_led[i] = 1'b0;
               end else if (m_en[i]) begin
                  if (m_tog[i]) begin
                     m_led[i]  = !m_led[i];
                     m_left[i] = m_half[i];
                  end else begin
                     m_left[i]--;
                  end
               end
            end
         end
      end
   end

   initial forever begin
      @(negedge CLK);
      chk("led", int'(LED), int'(exp_led()));
      chk("ready", int'(cfg_ready), int'(m_ph == 0));
      chk("busy", int'(busy), int'(m_ph != 0));
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic cfg_req(input int ch, input int div, input bit en,
                          input int hold);
      bit acc;
      bit r;
      @(posedge CLK);
      #2;
      cfg_valid = 1'b1;
      cfg_ch    = 2'(ch);
      cfg_div   = CNT_W'(div);
      cfg_en    = en;
      acc = 1'b0;
      for (int k = 0; k < 200 && !acc; k++) begin
         @(negedge CLK);
         r = cfg_ready;
         @(posedge CLK);
         #2;
         if (r) acc = 1'b1;
      end
      chk("accept", int'(acc), 1);
      repeat (hold) begin
         @(posedge CLK);
         #2;
      end
      cfg_valid = 1'b0;
   endtask

   task automatic next_change(input int ch, output int t);
      logic rv;
      bit   got;
      rv  = LED[ch];
      got = 1'b0;
      t   = 0;
      for (int k = 0; k < 400 && !got; k++) begin
         @(negedge CLK);
         if (LED[ch] !== rv) begin
            got = 1'b1;
            t   = int'($time / 10);
         end
      end
      if (!got) chk("change_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      bit idle;
      idle = 1'b0;
      for (int k = 0; k < 200 && !idle; k++) begin
         @(negedge CLK);
         if (!busy) idle = 1'b1;
      end
      if (!idle) chk("idle_timeout", 0, 1);
   endtask

   task automatic reset_release_pattern();
      @(posedge CLK);
      @(posedge CLK);
      #2;
      RST_N = 1'b1;
      repeat (4) begin
         @(negedge CLK);
         chk("post_rst_led_low", int'(LED), 0);
      end
      @(negedge CLK);
      chk("post_rst_first_toggle", int'(LED), 7);
      chk("post_rst_ready", int'(cfg_ready), 1);
      chk("post_rst_busy", int'(busy), 0);
   endtask

   int t0, t1, t2, a;

   initial begin
      @(posedge CLK);
      reset_release_pattern();

      // ch1 div=12 issued mid half-period: 7 then 6
      @(negedge CLK);
      cfg_req(1, 12, 1'b1, 0);
      @(negedge CLK);
      chk("ch1_wait_busy", int'(busy), 1);
      next_change(1, t0);
      chk("ch1_commit_busy", int'(busy), 1);
      @(negedge CLK);
      chk("ch1_done_busy", int'(busy), 0);
      chk("ch1_done_ready", int'(cfg_ready), 1);
      next_change(1, t1);
      next_change(1, t2);
      chk("ch1_first_half", t1 - t0, 7);
      chk("ch1_second_half", t2 - t1, 6);

      // ch2 disable, then re-enable with div=4
      cfg_req(2, 8, 1'b0, 0);
      @(negedge CLK);
      chk("ch2_dis_busy", int'(busy), 1);
      @(negedge CLK);
      chk("ch2_dis_led", int'(LED[2]), 0);
      chk("ch2_dis_idle", int'(busy), 0);
      repeat (6) begin
         @(negedge CLK);
         chk("ch2_held_low", int'(LED[2]), 0);
      end
      cfg_req(2, 4, 1'b1, 0);
      a = int'(($time + 3) / 10);
      next_change(2, t0);
      chk("ch2_en_rise", int'(LED[2]), 1);
      next_change(2, t1);
      chk("ch2_en_first", t0 - a, 3);
      chk("ch2_en_gap", t1 - t0, 2);

      // ch0 small and odd divisors
      cfg_req(0, 1, 1'b1, 0);
      wait_idle();
      repeat (3) @(negedge CLK);
      next_change(0, t0);
      next_change(0, t1);
      chk("ch0_div1_gap", t1 - t0, 1);
      cfg_req(0, 0, 1'b1, 0);
      wait_idle();
      repeat (3) @(negedge CLK);
      next_change(0, t0);
      next_change(0, t1);
      chk("ch0_div0_gap", t1 - t0, 1);
      cfg_req(0, 7, 1'b1, 0);
      wait_idle();
      repeat (8) @(negedge CLK);
      next_change(0, t0);
      next_change(0, t1);
      chk("ch0_div7_gap", t1 - t0, 3);

      // out-of-range channel, valid held into the busy cycle
      cfg_req(3, 5, 1'b1, 0);
      @(negedge CLK);
      chk("ch3_busy", int'(busy), 1);
      @(negedge CLK);
      chk("ch3_done", int'(busy), 0);
      cfg_req(3, 9, 1'b1, 1);
      @(negedge CLK);
      chk("ch3_hold_idle", int'(busy), 0);
      @(negedge CLK);
      chk("ch3_no_reaccept", int'(busy), 0);

      // reset while waiting for a boundary
      cfg_req(0, 200, 1'b1, 0);
      chk("wait_busy_pre_rst", int'(busy), 1);
      RST_N = 1'b0;
      #1;
      chk("rst_led", int'(LED), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ready", int'(cfg_ready), 1);
      reset_release_pattern();
      next_change(0, t0);
      next_change(0, t1);
      chk("ch0_restored_gap", t1 - t0, 4);
      repeat (4) @(negedge CLK);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/led_divider_ctrl.md
LED_DIVIDER_CTRL -- requirements
Module: led_divider_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of divided LED outputs.
REQ-002 SHALL have parameter CNT_W, default 26: divisor and counter width.
REQ-003 SHALL have parameter DIV_RESET, default 50000000: per-channel divisor after reset.
REQ-004 SHALL have port CLK, input, 1: single clock.
REQ-005 SHALL have port RST_N, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port cfg_valid, input, 1: config request valid.
REQ-007 SHALL have port cfg_ready, output, 1: config request accepted when valid&ready.
REQ-008 SHALL have port cfg_ch, input, 2: target channel index.
REQ-009 SHALL have port cfg_div, input, CNT_W: new divisor (full output period in CLK cycles).
REQ-010 SHALL have port cfg_en, input, 1: new channel enable.
REQ-011 SHALL have port LED, output, NUM_CH: divided outputs, one bit per channel.
REQ-012 SHALL have port busy, output, 1: config FSM not in IDLE.

Function
REQ-013 SHALL compute per-channel half = max(div,2)>>1; output period = 2*half (odd div rounds down, div<2 treated as 2).
REQ-014 SHALL, per enabled channel, count cnt 0..half-1; on cnt==half-1 ("boundary cycle") set cnt<=0 and toggle LED[i].
REQ-015 SHALL hold a disabled channel at cnt=0, LED[i]=0, no boundary cycles.
REQ-016 SHALL run config FSM states IDLE, WAIT_BND, COMMIT; cfg_ready=1 only in IDLE; busy=(state!=IDLE).
REQ-017 IDLE: on cfg_valid&cfg_ready latch cfg_ch/cfg_div/cfg_en; go COMMIT if target disabled, cfg_en=0, or cfg_ch>=NUM_CH; else go WAIT_BND.
REQ-018 WAIT_BND: stay until target channel boundary cycle (toggle occurs normally), then go COMMIT.
REQ-019 COMMIT: one cycle; at its end write latched div/en to target, clear target cnt to 0, keep LED[i] unless en=0 (LED forced 0); go IDLE.
REQ-020 SHALL make cfg_ch>=NUM_CH a no-op commit (handshake completes, no channel changed).
REQ-021 Latency: request accepted at edge T with disabled target -> new settings in effect from edge T+2; cfg_ready high again cycle after COMMIT.
REQ-022 SHALL give first half-period after an enabled-channel commit of new_half+1 cycles (boundary cycle precedes COMMIT), then new_half thereafter.
REQ-023 SHALL keep non-target channels counting undisturbed during all FSM states.
REQ-024 SHALL ignore cfg_* inputs when cfg_ready=0; no queuing, one request in flight.
REQ-025 Enabling a disabled channel SHALL start it with LED=0, cnt=0; first toggle after half cycles.

Reset
REQ-026 RST_N low SHALL asynchronously set all div=DIV_RESET, en=1, cnt=0, LED=0, state=IDLE, latched request cleared.
REQ-027 After RST_N deasserts, cfg_ready SHALL be 1 and busy 0; reset during WAIT_BND/COMMIT SHALL abandon the request with no partial write.

Structure
REQ-028 Shared package led_div_pkg SHALL hold the FSM state enum, default NUM_CH/CNT_W/DIV_RESET constants and the half-period clamp function.
REQ-029 SHALL instantiate sub-module div_channel per channel (counter, toggle, load port, enable), FSM in top level.

Verification (DIV_RESET=8, CNT_W=8 for sim)
REQ-030 Reset release -> all LED toggle every 4 cycles in phase, cfg_ready=1, busy=0.
REQ-031 Write ch1 div=12 en=1 mid-half-period -> busy until ch1 boundary+1 cycle, then ch1 half-periods 7,6,6,...; ch0/ch2 unchanged.
REQ-032 Write ch2 en=0 -> LED[2]=0 two edges after accept; then ch2 en=1 div=4 -> LED[2] toggles every 2 cycles starting from 0.
REQ-033 Write ch0 div=1 and div=0 -> both behave as div=2 (toggle every cycle); div=7 -> toggle every 3 cycles.
REQ-034 Write cfg_ch=3 -> handshake completes in 2 cycles, all LED waveforms unchanged; cfg_valid held during busy -> no second accept.
REQ-035 Assert RST_N low during WAIT_BND -> immediate LED=0, state IDLE, old divisors restored to DIV_RESET, pending write never applied.
